// File: rtl/ad9226_capture_ctrl_if.sv
// Capture RAM write port bundle.
// Master drives one-cycle write strobes with address and data.
interface ad9226_capture_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 13
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input wr_en, input wr_addr, input wr_data);
endinterface

// File: rtl/ad9226_capture_ctrl.sv
// Triggered AD9226 acquisition sequencer feeding a capture RAM.
// Optional macro CAPTURE_TIMEOUT_EN adds a forced-trigger timeout.
module ad9226_capture_ctrl #(
  parameter int ADDR_W          = 10,
  parameter int DATA_W          = 13,
  parameter int TIMEOUT_SAMPLES = 65536
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              i_sample_valid,
  input  logic [DATA_W-1:0] i_sample_data,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [DATA_W-1:0] i_trig_level,
  input  logic              i_trig_slope,
  input  logic [ADDR_W-1:0] i_depth,
  input  logic [7:0]        i_decim,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_timed_out,
  output logic [2:0]        o_state,
  ad9226_capture_ctrl_if.master ram
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARM       = 3'd1,
    WAIT_TRIG = 3'd2,
    CAPTURE   = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] level;
  logic [DATA_W-1:0] prev;
  logic              slope;
  logic [ADDR_W-1:0] depth;
  logic [ADDR_W-1:0] count;
  logic [7:0]        decim;
  logic [7:0]        dcnt;
  logic              hit;
  logic              force_trig;
  logic              trig;
  logic              accept;

  assign o_state = state;
  assign accept  = i_start && (state == IDLE || state == DONE);
  assign trig    = hit | force_trig;

  // Level crossing between the held previous sample and the current one.
  always_comb begin
    if (slope) hit = (prev > level) && (i_sample_data <= level);
    else       hit = (prev < level) && (i_sample_data >= level);
  end

`ifdef CAPTURE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_SAMPLES + 1);

  logic [TW-1:0] tcnt;
  logic          timed_out;

  assign force_trig  = (tcnt == TW'(TIMEOUT_SAMPLES));
  assign o_timed_out = timed_out;

  // Count untriggered samples in WAIT_TRIG; force a trigger at the limit.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tcnt      <= '0;
      timed_out <= 1'b0;
    end else if (i_abort) begin
      timed_out <= 1'b0;
    end else if (accept) begin
      tcnt      <= '0;
      timed_out <= 1'b0;
    end else if (state == WAIT_TRIG && i_sample_valid) begin
      if (force_trig) timed_out <= 1'b1;
      else            tcnt      <= tcnt + TW'(1);
    end
  end
`else
  assign force_trig  = 1'b0;
  // No timeout hardware: the flag is a constant low.
  assign o_timed_out = (TIMEOUT_SAMPLES < 0);
`endif

  // Sequencer: state, status flags and registered RAM write port.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      ram.wr_en   <= 1'b0;
      ram.wr_addr <= '0;
      ram.wr_data <= '0;
      level       <= '0;
      slope       <= 1'b0;
      depth       <= '0;
      decim       <= '0;
      prev        <= '0;
      count       <= '0;
      dcnt        <= '0;
    end else begin
      ram.wr_en <= 1'b0;
      if (i_abort) begin
        state  <= IDLE;
        o_busy <= 1'b0;
        o_done <= 1'b0;
      end else if (accept) begin
        level  <= i_trig_level;
        slope  <= i_trig_slope;
        depth  <= i_depth;
        decim  <= i_decim;
        state  <= ARM;
        o_busy <= 1'b1;
        o_done <= 1'b0;
      end else if (i_sample_valid) begin
        case (state)
          ARM: begin
            prev  <= i_sample_data;
            state <= WAIT_TRIG;
          end
          WAIT_TRIG: begin
            if (trig) begin
              ram.wr_en   <= 1'b1;
              ram.wr_addr <= '0;
              ram.wr_data <= i_sample_data;
              count       <= ADDR_W'(1);
              dcnt        <= '0;
              if (depth == '0) begin
                state  <= DONE;
                o_busy <= 1'b0;
                o_done <= 1'b1;
              end else begin
                state <= CAPTURE;
              end
            end else begin
              prev <= i_sample_data;
            end
          end
          CAPTURE: begin
            if (dcnt == decim) begin
              dcnt        <= '0;
              ram.wr_en   <= 1'b1;
              ram.wr_addr <= count;
              ram.wr_data <= i_sample_data;
              count       <= count + ADDR_W'(1);
              if (count == depth) begin
                state  <= DONE;
                o_busy <= 1'b0;
                o_done <= 1'b1;
              end
            end else begin
              dcnt <= dcnt + 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ad9226_capture_ctrl.sv
// Randomized + directed bench for ad9226_capture_ctrl.
// Sample-index reference model checked every cycle.
module tb_ad9226_capture_ctrl;
  localparam int AW = 10;
  localparam int DW = 13;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_sample_valid = 1'b0;
  logic [DW-1:0] i_sample_data = '0;
  logic          i_start = 1'b0;
  logic          i_abort = 1'b0;
  logic [DW-1:0] i_trig_level = '0;
  logic          i_trig_slope = 1'b0;
  logic [AW-1:0] i_depth = '0;
  logic [7:0]    i_decim = '0;
  logic          o_busy;
  logic          o_done;
  logic          o_timed_out;
  logic [2:0]    o_state;

  ad9226_capture_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) ram_if ();

  ad9226_capture_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_SAMPLES(TO)
  ) dut (
    .sys_clk(clk),
    .sys_rst_n(rst_n),
    .i_sample_valid(i_sample_valid),
    .i_sample_data(i_sample_data),
    .i_start(i_start),
    .i_abort(i_abort),
    .i_trig_level(i_trig_level),
    .i_trig_slope(i_trig_slope),
    .i_depth(i_depth),
    .i_decim(i_decim),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_timed_out(o_timed_out),
    .o_state(o_state),
    .ram(ram_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int addr;
    int data;
    int done;
  } wr_t;
  wr_t log_q[$];

  // model: phase 0 idle, 1 acquiring, 2 done
  int ph = 0;
  int lvl, slp, dep, dec;
  int n, tidx, last;
  int m_wr, m_addr, m_data, m_to;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic model_step();
    int cur;
    int k;
    m_wr = 0;
    if (!rst_n) begin
      ph = 0;
      m_to = 0;
    end else if (i_abort) begin
      ph = 0;
      m_to = 0;
    end else if (i_start && ph != 1) begin
      ph = 1;
      lvl = int'(i_trig_level);
      slp = int'(i_trig_slope);
      dep = int'(i_depth);
      dec = int'(i_decim);
      n = 0;
      tidx = -1;
      m_to = 0;
    end else if (i_sample_valid && ph == 1) begin
      cur = int'(i_sample_data);
      if (n > 0 && tidx < 0) begin
        if (slp != 0 ? (last > lvl && cur <= lvl)
                     : (last < lvl && cur >= lvl))
          tidx = n;
`ifdef CAPTURE_TIMEOUT_EN
        if (n == TO + 1) begin
          tidx = n;
          m_to = 1;
        end
`endif
      end
      if (tidx >= 0 && (n - tidx) % (dec + 1) == 0) begin
        k = (n - tidx) / (dec + 1);
        m_wr = 1;
        m_addr = k;
        m_data = cur;
        if (k == dep) ph = 2;
      end
      last = cur;
      n++;
    end
  endtask

  function automatic int m_state();
    if (ph == 0) return 0;
    if (ph == 2) return 4;
    if (n == 0) return 1;
    if (tidx < 0) return 2;
    return 3;
  endfunction

  // Model advance on each edge, then compare every output.
  initial begin
    wr_t e;
    forever begin
      @(posedge clk);
      model_step();
      #1;
      if (rst_n) begin
        chk("wr_en", int'(ram_if.wr_en), m_wr);
        if (m_wr != 0) begin
          chk("wr_addr", int'(ram_if.wr_addr), m_addr);
          chk("wr_data", int'(ram_if.wr_data), m_data);
        end
        chk("busy", int'(o_busy), int'(ph == 1));
        chk("done", int'(o_done), int'(ph == 2));
        chk("state", int'(o_state), m_state());
        chk("timed_out", int'(o_timed_out), m_to);
      end
      if (ram_if.wr_en) begin
        e.addr = int'(ram_if.wr_addr);
        e.data = int'(ram_if.wr_data);
        e.done = int'(o_done);
        log_q.push_back(e);
      end
    end
  end

  task automatic step(input bit v, input int d,
                      input bit s = 1'b0, input bit a = 1'b0);
    i_sample_valid = v;
    i_sample_data  = DW'(d);
    i_start        = s;
    i_abort        = a;
    @(negedge clk);
    i_sample_valid = 1'b0;
    i_start        = 1'b0;
    i_abort        = 1'b0;
  endtask

  task automatic cfg(input int l, input bit s, input int d, input int m);
    i_trig_level = DW'(l);
    i_trig_slope = s;
    i_depth      = AW'(d);
    i_decim      = 8'(m);
  endtask

  initial begin
    int t1[6] = '{2000, 2040, 2050, 2060, 2070, 2080};
    int t2[5] = '{1010, 990, 980, 970, 960};

    repeat (2) @(negedge clk);
    chk("rst_wr_en", int'(ram_if.wr_en), 0);
    chk("rst_wr_addr", int'(ram_if.wr_addr), 0);
    chk("rst_wr_data", int'(ram_if.wr_data), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_done", int'(o_done), 0);
    chk("rst_state", int'(o_state), 0);
    chk("rst_timed_out", int'(o_timed_out), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // rising trigger, decim 0
    log_q.delete();
    cfg(2048, 1'b0, 3, 0);
    step(0, 0, 1'b1);
    chk("t1_arm", int'(o_state), 1);
    foreach (t1[i]) step(1, t1[i]);
    step(0, 0);
    step(0, 0);
    chk("t1_nwr", log_q.size(), 4);
    if (log_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("t1_addr", log_q[i].addr, i);
        chk("t1_data", log_q[i].data, 2050 + 10 * i);
      end
      chk("t1_done_w2", log_q[2].done, 0);
      chk("t1_done_w3", log_q[3].done, 1);
    end

    // falling trigger with decimation, restarted from DONE
    log_q.delete();
    cfg(1000, 1'b1, 1, 2);
    step(0, 0, 1'b1);
    chk("t2_done_clr", int'(o_done), 0);
    foreach (t2[i]) begin
      step(1, t2[i]);
      step(0, 0);
    end
    chk("t2_state", int'(o_state), 4);
    chk("t2_nwr", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("t2_w0", log_q[0].addr * 10000 + log_q[0].data, 990);
      chk("t2_w1", log_q[1].addr * 10000 + log_q[1].data, 10960);
    end

    // already above level: no false trigger
    log_q.delete();
    cfg(2048, 1'b0, 5, 0);
    step(0, 0, 1'b1);
    repeat (10) step(1, 3000);
    chk("t3_state", int'(o_state), 2);
    chk("t3_nwr", log_q.size(), 0);
    step(0, 0, 1'b0, 1'b1);

    // abort mid-capture together with start
    log_q.delete();
    cfg(2048, 1'b0, 7, 0);
    step(0, 0, 1'b1);
    step(1, 2000);
    step(1, 2100);
    step(1, 2110);
    chk("t4_nwr2", log_q.size(), 2);
    step(1, 2120, 1'b1, 1'b1);
    chk("t4_state", int'(o_state), 0);
    chk("t4_busy", int'(o_busy), 0);
    chk("t4_done", int'(o_done), 0);
    chk("t4_wr_en", int'(ram_if.wr_en), 0);
    repeat (5) step(1, 3000);
    chk("t4_nwr_after", log_q.size(), 2);
    step(0, 0, 1'b1);
    step(1, 100);
    step(1, 3000);
    chk("t4_nwr_restart", log_q.size(), 3);
    if (log_q.size() == 3) begin
      chk("t4_re_addr", log_q[2].addr, 0);
      chk("t4_re_data", log_q[2].data, 3000);
    end
    step(0, 0, 1'b0, 1'b1);

    // start during capture is ignored
    log_q.delete();
    cfg(2048, 1'b0, 2, 0);
    step(0, 0, 1'b1);
    step(1, 0);
    step(1, 4000);
    i_depth = AW'(9);
    step(1, 4001, 1'b1);
    step(1, 4002);
    step(0, 0);
    chk("t5_state", int'(o_state), 4);
    chk("t5_nwr", log_q.size(), 3);
    if (log_q.size() == 3) chk("t5_last_done", log_q[2].done, 1);
    step(0, 0, 1'b0, 1'b1);

    // flat input for 1000 samples below the level
    log_q.delete();
    cfg(2048, 1'b0, 3, 0);
    step(0, 0, 1'b1);
    repeat (1000) step(1, 500);
`ifdef CAPTURE_TIMEOUT_EN
    chk("t6_timed_out", int'(o_timed_out), 1);
    chk("t6_nwr", log_q.size(), 4);
    chk("t6_state", int'(o_state), 4);
`else
    chk("t6_nwr", log_q.size(), 0);
    chk("t6_state", int'(o_state), 2);
`endif
    step(0, 0, 1'b0, 1'b1);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 3) == 0)
        cfg($urandom_range(0, 8191), 1'($urandom_range(0, 1)),
            $urandom_range(0, 12), $urandom_range(0, 3));
      step(1'($urandom_range(0, 9) < 7), $urandom_range(0, 8191),
           1'($urandom_range(0, 39) == 0),
           1'($urandom_range(0, 149) == 0));
    end
    step(0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
